// File: rtl/au_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial AU sequencer: opcodes, AU select
// codes, AU carry-vector bit indices and the sequencer state encoding.
package au_seq_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;

  localparam logic [1:0] AU_ADD = 2'b00;
  localparam logic [1:0] AU_INC = 2'b01;
  localparam logic [1:0] AU_DEC = 2'b10;
  localparam logic [1:0] AU_SHL = 2'b11;

  // Bit positions inside the AU's per-op carry vector.
  localparam logic [1:0] CO_ADD = 2'd0;
  localparam logic [1:0] CO_INC = 2'd1;
  localparam logic [1:0] CO_DEC = 2'd2;
  localparam logic [1:0] CO_SHL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SHL;
  endfunction

endpackage

// File: rtl/au_nib_mux.sv
// Combinational mapping of (op, pass, operands, link bit) onto the AU inputs,
// plus which AU carry bit feeds the link/carry and how it is post-processed.
module au_nib_mux
  import au_seq_ctrl_pkg::*;
(
  input  logic       active_i,
  input  logic       pass_hi_i,
  input  logic [2:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  input  logic       k_i,
  output logic [3:0] au_a_o,
  output logic [3:0] au_b_o,
  output logic       au_cin_o,
  output logic [1:0] au_s_o,
  output logic [1:0] c_sel_o,
  output logic       c_inv_o,
  output logic       c_zero_o
);

  logic [3:0] a_nib;
  logic [3:0] b_nib;

  assign a_nib = pass_hi_i ? a_i[7:4] : a_i[3:0];
  assign b_nib = pass_hi_i ? b_i[7:4] : b_i[3:0];

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned; a missed branch in always_comb would infer a latch.
  always_comb begin
    au_a_o   = '0;
    au_b_o   = '0;
    au_cin_o = 1'b0;
    au_s_o   = AU_ADD;
    c_sel_o  = CO_ADD;
    c_inv_o  = 1'b0;
    c_zero_o = 1'b0;
    if (active_i) begin
      au_a_o = a_nib;
      case (op_i)
        OP_ADD: begin
          au_b_o   = b_nib;
          au_cin_o = pass_hi_i ? k_i : cin_i;
        end
        OP_SUB: begin
          au_b_o   = ~b_nib;
          au_cin_o = pass_hi_i ? k_i : 1'b1;
          c_inv_o  = pass_hi_i;
        end
        OP_INC: begin
          if (!pass_hi_i) begin
            au_s_o  = AU_INC;
            c_sel_o = CO_INC;
          end else begin
            au_cin_o = k_i;
          end
        end
        OP_DEC: begin
          // Without a borrow out of the low nibble the high nibble passes through.
          if (!pass_hi_i || k_i) begin
            au_s_o  = AU_DEC;
            c_sel_o = CO_DEC;
          end else begin
            c_zero_o = 1'b1;
          end
        end
        OP_SHL: begin
          if (!pass_hi_i) begin
            au_s_o  = AU_SHL;
            c_sel_o = CO_SHL;
          end else begin
            au_b_o   = a_nib;
            au_cin_o = k_i;
          end
        end
        default: c_zero_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/au_seq_ctrl.sv
// Runs 8-bit ADD/SUB/INC/DEC/SHL on a shared 4-bit AU as two nibble passes
// (low then high) and returns an 8-bit result with flags and a done pulse.
module au_seq_ctrl
  import au_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_cin,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic       au_cin,
  output logic [1:0] au_s,
  input  logic [3:0] au_y,
  input  logic [3:0] au_cout,
  output logic       res_valid,
  output logic [7:0] res_y,
  output logic       res_c,
  output logic       res_z,
  output logic       res_v,
  output logic       res_err
);

  state_e     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic       cin_q;
  logic       k_q;
  logic [3:0] lo_q;
  logic [7:0] res_y_q, res_y_d;
  logic       res_c_q, res_c_d;
  logic       res_z_q, res_z_d;
  logic       res_v_q, res_v_d;
  logic       res_err_q, res_err_d;

  logic [1:0] c_sel;
  logic       c_inv, c_zero, link;
  logic       b7_eff;

  au_nib_mux u_nib_mux (
    .active_i (state_q == ST_LO || state_q == ST_HI),
    .pass_hi_i(state_q == ST_HI),
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .cin_i    (cin_q),
    .k_i      (k_q),
    .au_a_o   (au_a),
    .au_b_o   (au_b),
    .au_cin_o (au_cin),
    .au_s_o   (au_s),
    .c_sel_o  (c_sel),
    .c_inv_o  (c_inv),
    .c_zero_o (c_zero)
  );

  assign link = au_cout[c_sel];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result and flags as they will be latched at the end of the high pass.
  always_comb begin
    res_y_d = {au_y, lo_q};
    if (op_q == OP_SHL) res_y_d[0] = 1'b0;
    if (!op_legal(op_q)) res_y_d = a_q;
    res_err_d = !op_legal(op_q);
    res_c_d   = c_zero ? 1'b0 : (link ^ c_inv);
    res_z_d   = (res_y_d == 8'h00);
    b7_eff    = (op_q == OP_SUB) ? ~b_q[7] : b_q[7];
    res_v_d   = (op_q == OP_ADD || op_q == OP_SUB) &&
                (a_q[7] == b7_eff) && (res_y_d[7] != a_q[7]);
  end

  // NOTE: state elements use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      k_q       <= 1'b0;
      lo_q      <= '0;
      res_y_q   <= '0;
      res_c_q   <= 1'b0;
      res_z_q   <= 1'b0;
      res_v_q   <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        cin_q <= cmd_cin;
      end
      if (state_q == ST_LO) begin
        lo_q <= au_y;
        k_q  <= link;
      end
      if (state_q == ST_HI) begin
        res_y_q   <= res_y_d;
        res_c_q   <= res_c_d;
        res_z_q   <= res_z_d;
        res_v_q   <= res_v_d;
        res_err_q <= res_err_d;
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_y     = res_y_q;
  assign res_c     = res_c_q;
  assign res_z     = res_z_q;
  assign res_v     = res_v_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_au_seq_ctrl.sv
// Directed bench for au_seq_ctrl with a behavioural 4-bit AU on the au_* ports.
module tb_au_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       cmd_cin;
  logic [3:0] au_a, au_b, au_y, au_cout;
  logic       au_cin;
  logic [1:0] au_s;
  logic       res_valid;
  logic [7:0] res_y;
  logic       res_c, res_z, res_v, res_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Values captured by run_cmd for the last command.
  logic [1:0] lo_s, hi_s;
  logic       lo_cin, hi_cin, early_valid, pulse_after;
  int         lat;
  logic [7:0] r_y;
  logic       r_c, r_z, r_v, r_err;

  always #5 clk = ~clk;

  au_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_cin  (cmd_cin),
    .au_a     (au_a),
    .au_b     (au_b),
    .au_cin   (au_cin),
    .au_s     (au_s),
    .au_y     (au_y),
    .au_cout  (au_cout),
    .res_valid(res_valid),
    .res_y    (res_y),
    .res_c    (res_c),
    .res_z    (res_z),
    .res_v    (res_v),
    .res_err  (res_err)
  );

  // Shared 4-bit AU: every carry bit is reported regardless of select.
  logic [4:0] au_sum;
  always_comb begin
    au_sum = {1'b0, au_a} + {1'b0, au_b} + {4'b0, au_cin};
    au_y   = au_sum[3:0];
    case (au_s)
      2'b01:   au_y = au_a + 4'd1;
      2'b10:   au_y = au_a - 4'd1;
      2'b11:   au_y = {au_a[2:0], 1'b0};
      default: au_y = au_sum[3:0];
    endcase
    au_cout = {au_a[3], (au_a == 4'h0), (au_a == 4'hF), au_sum[4]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge and follow it to its done pulse.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
    logic got;
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lo_s = au_s; lo_cin = au_cin; early_valid = res_valid;
    @(posedge clk); #1;
    hi_s = au_s; hi_cin = au_cin; early_valid = early_valid | res_valid;
    lat = 2; got = 1'b0;
    while (lat < 8 && !got) begin
      @(posedge clk); #1;
      lat++;
      got = res_valid;
    end
    r_y = res_y; r_c = res_c; r_z = res_z; r_v = res_v; r_err = res_err;
    if (!got) check("res_valid_timeout", 0, 1);
    @(posedge clk); #1;
    pulse_after = res_valid;
  endtask

  task automatic check_res(input string tag, input logic [7:0] y, input logic c,
                           input logic z, input logic v, input logic err);
    check({tag, ".y"}, r_y, y);
    check({tag, ".c"}, r_c, c);
    check({tag, ".z"}, r_z, z);
    check({tag, ".v"}, r_v, v);
    check({tag, ".err"}, r_err, err);
    check({tag, ".latency"}, lat, 3);
    check({tag, ".early_valid"}, early_valid, 0);
    check({tag, ".pulse_width"}, pulse_after, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ry[2];
    logic       rv[2];
    int         acc_edge[2];
    int         n_acc, n_res;
    logic       acc;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.cmd_ready", cmd_ready, 1);
    check("rst.res_valid", res_valid, 0);
    check("rst.res_y", res_y, 8'h00);
    check("rst.flags", {res_c, res_z, res_v, res_err}, 4'b0000);
    check("rst.au_drive", {au_a, au_b, au_cin, au_s}, 11'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(3'b000, 8'h3C, 8'h4F, 1'b0);
    check_res("add_3c_4f", 8'h8B, 0, 0, 1, 0);
    run_cmd(3'b001, 8'h10, 8'h01, 1'b0);
    check_res("sub_10_01", 8'h0F, 0, 0, 0, 0);
    run_cmd(3'b001, 8'h00, 8'h01, 1'b0);
    check_res("sub_00_01", 8'hFF, 1, 0, 0, 0);
    run_cmd(3'b010, 8'hFF, 8'h00, 1'b0);
    check_res("inc_ff", 8'h00, 1, 1, 0, 0);
    run_cmd(3'b011, 8'h10, 8'h00, 1'b0);
    check_res("dec_10", 8'h0F, 0, 0, 0, 0);
    check("dec_10.hi_s", hi_s, 2'b10);
    run_cmd(3'b011, 8'h00, 8'h00, 1'b0);
    check_res("dec_00", 8'hFF, 1, 0, 0, 0);
    run_cmd(3'b011, 8'h25, 8'h00, 1'b0);
    check_res("dec_25", 8'h24, 0, 0, 0, 0);
    check("dec_25.hi_s", hi_s, 2'b00);
    run_cmd(3'b100, 8'h81, 8'h00, 1'b0);
    check_res("shl_81", 8'h02, 1, 0, 0, 0);
    check("shl_81.lo_s", lo_s, 2'b11);
    check("shl_81.hi_cin", hi_cin, 0);
    run_cmd(3'b111, 8'h5A, 8'hFF, 1'b1);
    check_res("illegal_111", 8'h5A, 0, 0, 0, 1);
    check("illegal_111.lo_s", lo_s, 2'b00);

    // Back-to-back with cmd_valid held high: the second accept is 4 edges later.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'h01; cmd_b = 8'h02; cmd_cin = 1'b0;
    n_acc = 0; n_res = 0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    for (int e = 1; e <= 16 && n_res < 2; e++) begin
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      if (acc && n_acc < 2) begin
        acc_edge[n_acc] = e;
        n_acc++;
      end
      #1;
      if (res_valid && n_res < 2) begin
        ry[n_res] = res_y;
        rv[n_res] = res_v;
        n_res++;
      end
      @(negedge clk);
      if (acc) begin
        if (n_acc == 1) begin
          cmd_a = 8'h7F; cmd_b = 8'h01;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    check("b2b.accepts", n_acc, 2);
    check("b2b.results", n_res, 2);
    check("b2b.spacing", acc_edge[1] - acc_edge[0], 4);
    check("b2b.y0", ry[0], 8'h03);
    check("b2b.y1", ry[1], 8'h80);
    check("b2b.v1", rv[1], 1);

    // Reset while the high pass is in progress.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'h3C; cmd_b = 8'h4F; cmd_cin = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_hi.in_hi", {cmd_ready, res_valid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_hi.res_valid", res_valid, 0);
    check("rst_hi.res_y", res_y, 8'h00);
    check("rst_hi.flags", {res_c, res_z, res_v, res_err}, 4'b0000);
    check("rst_hi.cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_hi.no_late_valid", res_valid, 0);
    run_cmd(3'b000, 8'hFF, 8'h01, 1'b1);
    check_res("add_after_rst", 8'h01, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/au_seq_ctrl.md
Name: au_seq_ctrl

Overview:
- Sequencer that runs 8-bit operations on the shared 4-bit arithmetic unit by time-multiplexing it over two nibble passes: low nibble first, then high nibble.
- Accepts one command at a time over a start/ready handshake.
- Drives the AU's A/B/Cin/S inputs and captures the AU's Y and per-op carry outputs between passes.
- Returns an 8-bit result plus flags with a one-cycle done pulse.
- Sits between the datapath's command source and the single AU instance.

Parameters:
- none: all widths are fixed by the AU contract (4-bit nibble, 2-bit select, 4-bit per-op carry vector).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
- cmd_op  in  3  000 ADD, 001 SUB, 010 INC, 011 DEC, 100 SHL, others illegal
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B (ADD/SUB only)
- cmd_cin  in  1  carry-in (ADD only)
- au_a  out  4  AU operand A
- au_b  out  4  AU operand B
- au_cin  out  1  AU carry-in
- au_s  out  2  AU select: 00 add, 01 inc, 10 dec, 11 shl
- au_y  in  4  AU result
- au_cout  in  4  AU carries: [0] adder carry, [1] inc carry (A==F), [2] dec borrow (A==0), [3] shifted-out A[3]
- res_valid  out  1  one-cycle done pulse
- res_y  out  8  result, held until next completion
- res_c  out  1  ADD/INC/SHL: carry out; SUB/DEC: borrow out
- res_z  out  1  res_y==0
- res_v  out  1  signed overflow (ADD/SUB only, else 0)
- res_err  out  1  illegal opcode

Behaviour:
- Reset:
  - Synchronous, rst_n low at a clock edge forces IDLE.
  - All res_* and captured state clear to 0; cmd_ready=1 after reset.
  - Reset mid-operation abandons the command with no res_valid.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
  - Operands are registered on accept in IDLE.
  - LO: drive low nibble; register au_y into res_y[3:0] and the relevant au_cout bit as the link bit k.
  - HI: drive high nibble using k; register au_y into res_y[7:4] and compute flags.
  - DONE: res_valid=1 for exactly one cycle.
- Latency: accept at edge N; res_valid high in cycle N+3. Throughput: one command per 4 cycles.
- cmd_ready=0 in LO, HI and DONE. cmd_valid is ignored there; the command is not queued.
- AU drive in IDLE/DONE: au_a=0, au_b=0, au_cin=0, au_s=00.
- Nibble mapping (lo pass / hi pass):
  - ADD: lo S=00, A=a[3:0], B=b[3:0], Cin=cin, k=cout[0]. hi S=00, A=a[7:4], B=b[7:4], Cin=k. res_c=cout[0].
  - SUB: same as ADD with B=~b nibble; lo Cin=1. res_c=~cout[0] of hi pass.
  - INC: lo S=01, A=a[3:0], k=cout[1]. hi S=00, A=a[7:4], B=0, Cin=k. res_c=cout[0].
  - DEC: lo S=10, A=a[3:0], k=cout[2]. hi: if k then S=10, A=a[7:4], res_c=cout[2]; else S=00, B=0, Cin=0, res_c=0.
  - SHL: lo S=11, A=a[3:0], k=cout[3]. hi S=00, A=B=a[7:4], Cin=k. res_c=cout[0] (=a[7]). res_y[0]=0.
  - Illegal opcode: both passes S=00, B=0, Cin=0. res_y=cmd_a, res_err=1, res_c=res_v=0.
- res_v, with b' = b for ADD and ~b for SUB: (a[7]==b'[7]) && (res_y[7]!=a[7]).
- res_* update only in HI→DONE and hold until the next completion or reset.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_ADD..OP_SHL)
  - AU select constants (AU_ADD=00, AU_INC=01, AU_DEC=10, AU_SHL=11)
  - au_cout bit indices
  - FSM state encoding
- One sub-module: au_nib_mux, a combinational mapping of (op, pass, operands, k) to au_a/au_b/au_cin/au_s and link-bit select. The FSM and registers stay in au_seq_ctrl.
- The bench instantiates the existing AU and connects it to the au_* ports.

Test Plan:
- ADD a=0x3C, b=0x4F, cin=0 -> res_y=0x8B, res_c=0, res_v=1, res_z=0, res_valid at accept+3.
- SUB a=0x10, b=0x01 -> res_y=0x0F, res_c=0. SUB a=0x00, b=0x01 -> 0xFF, res_c=1.
- INC a=0xFF -> res_y=0x00, res_c=1, res_z=1. DEC a=0x10 -> 0x0F with hi pass au_s=10. DEC a=0x00 -> 0xFF, res_c=1.
- SHL a=0x81 -> res_y=0x02, res_c=1. Check lo pass au_s=11 and hi pass au_cin=0.
- cmd_valid held high continuously with 2 commands -> second accepted only at cycle 4 after first accept. cmd_op=111 -> res_y=cmd_a, res_err=1.
- rst_n low during HI -> no res_valid, res_*=0, cmd_ready=1 next cycle; following ADD completes normally.
